// File: rtl/ahb_regbank_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the register bank slave.
// Pure declarations: no latency, no backpressure.
package ahb_regbank_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_RD_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_e;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe from (offset, hsize): lanes offset .. offset+2^hsize-1 set.
// Purely combinational, zero latency, no backpressure.
module ahb_strb_gen #(
   parameter int LANES = 4,
   parameter int OFF_W = $clog2(LANES)
) (
   input  logic [OFF_W-1:0] offset_i,
   input  logic [2:0]       hsize_i,
   output logic [LANES-1:0] strb_o
);

   int lo;
   int hi;

   always_comb begin
      strb_o = '0;
      lo     = int'(offset_i);
      hi     = lo + (1 << hsize_i);
      for (int l = 0; l < LANES; l++) begin
         strb_o[l] = (l >= lo) && (l < hi);
      end
   end

endmodule

// File: rtl/ahb_regbank_fanin.sv
// AHB-Lite slave register bank with byte strobes and two-cycle ERROR on illegal access.
// Writes and READ_PIPE=0 reads are zero-wait; READ_PIPE=1 reads and errors hold hready low one cycle.
module ahb_regbank_fanin
   import ahb_regbank_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    N_REGS     = 4,
   parameter int                    ADDR_WIDTH = $clog2(N_REGS) + $clog2(DATA_WIDTH/8),
   parameter int                    READ_PIPE  = 0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_ahb_hsel,
   input  logic                         s_ahb_hwrite,
   input  logic [1:0]                   s_ahb_htrans,
   input  logic [2:0]                   s_ahb_hsize,
   input  logic [ADDR_WIDTH-1:0]        s_ahb_haddr,
   input  logic [DATA_WIDTH-1:0]        s_ahb_hwdata,
   output logic                         s_ahb_hready,
   output logic [DATA_WIDTH-1:0]        s_ahb_hrdata,
   output logic                         s_ahb_hresp,
   output logic [N_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [N_REGS-1:0]            reg_wr
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(LANES);
   localparam int IDX_W = (ADDR_WIDTH > OFF_W) ? (ADDR_WIDTH - OFF_W) : 1;

   state_e                state_q;
   logic                  hready_q;
   logic                  hresp_q;
   logic [IDX_W-1:0]      idx_q;
   logic [OFF_W-1:0]      off_q;
   logic [2:0]            size_q;
   logic [DATA_WIDTH-1:0] regs_q [N_REGS];
   logic [N_REGS-1:0]     reg_wr_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [OFF_W-1:0]      addr_off;
   logic [IDX_W-1:0]      addr_idx;
   logic                  size_bad;
   logic                  align_bad;
   logic                  range_bad;
   logic                  acc_illegal;
   logic                  accept;
   logic [LANES-1:0]      strb;
   logic [DATA_WIDTH-1:0] rd_word_d;
   logic [DATA_WIDTH-1:0] wr_word_d;

   assign accept = s_ahb_hsel && hready_q &&
                   ((s_ahb_htrans == HTRANS_NONSEQ) || (s_ahb_htrans == HTRANS_SEQ));

   always_comb begin
      addr_off  = s_ahb_haddr[OFF_W-1:0];
      addr_idx  = IDX_W'(s_ahb_haddr >> OFF_W);
      size_bad  = s_ahb_hsize > 3'(OFF_W);
      align_bad = 1'b0;
      for (int b = 0; b < OFF_W; b++) begin
         if ((b < int'(s_ahb_hsize)) && addr_off[b]) begin
            align_bad = 1'b1;
         end
      end
      range_bad   = int'(addr_idx) >= N_REGS;
      acc_illegal = size_bad | align_bad | range_bad;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         idx_q    <= '0;
         off_q    <= '0;
         size_q   <= '0;
      end else begin
         case (state_q)
            ST_RD_WAIT: begin
               state_q  <= ST_RD_DATA;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_OKAY;
            end
            ST_ERR1: begin
               state_q  <= ST_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_ERROR;
            end
            default: begin
               // IDLE, WR_DATA, RD_DATA and ERR2 all take a pipelined address phase
               if (accept) begin
                  idx_q  <= addr_idx;
                  off_q  <= addr_off;
                  size_q <= s_ahb_hsize;
                  if (acc_illegal) begin
                     state_q  <= ST_ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_ERROR;
                  end else if (s_ahb_hwrite) begin
                     state_q  <= ST_WR_DATA;
                     hready_q <= 1'b1;
                     hresp_q  <= HRESP_OKAY;
                  end else if (READ_PIPE != 0) begin
                     state_q  <= ST_RD_WAIT;
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_OKAY;
                  end else begin
                     state_q  <= ST_RD_DATA;
                     hready_q <= 1'b1;
                     hresp_q  <= HRESP_OKAY;
                  end
               end else begin
                  state_q  <= ST_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   ahb_strb_gen #(
      .LANES (LANES),
      .OFF_W (OFF_W)
   ) u_strb (
      .offset_i (off_q),
      .hsize_i  (size_q),
      .strb_o   (strb)
   );

   always_comb begin
      rd_word_d = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            rd_word_d = regs_q[i];
         end
      end
      wr_word_d = rd_word_d;
      for (int l = 0; l < LANES; l++) begin
         if (strb[l]) begin
            wr_word_d[l*8 +: 8] = s_ahb_hwdata[l*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         reg_wr_q <= '0;
      end else begin
         reg_wr_q <= '0;
         if (state_q == ST_WR_DATA) begin
            for (int i = 0; i < N_REGS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  regs_q[i]   <= wr_word_d;
                  reg_wr_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Captured at the end of RD_WAIT so a write completing just before is already visible
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (state_q == ST_RD_WAIT) begin
         rdata_q <= rd_word_d;
      end else begin
         rdata_q <= '0;
      end
   end

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < N_REGS; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
      end
   end

   assign s_ahb_hready = hready_q;
   assign s_ahb_hresp  = hresp_q;
   assign s_ahb_hrdata = (READ_PIPE != 0) ? rdata_q :
                         ((state_q == ST_RD_DATA) ? rd_word_d : '0);
   assign reg_wr       = reg_wr_q;

endmodule

// File: tb/tb_ahb_regbank_fanin.sv
// Bench for ahb_regbank_fanin: instance 0 uses READ_PIPE=0, instance 1 READ_PIPE=1,
// both checked against a transaction-level register model.
module tb_ahb_regbank_fanin;

   typedef struct {
      bit          sel;
      logic [1:0]  trans;
      bit          wr;
      logic [5:0]  addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         hsel   [2] = '{1'b0, 1'b0};
   logic         hwrite [2] = '{1'b0, 1'b0};
   logic [1:0]   htrans [2] = '{2'b00, 2'b00};
   logic [2:0]   hsize  [2] = '{3'd0, 3'd0};
   logic [5:0]   haddr  [2] = '{6'd0, 6'd0};
   logic [31:0]  hwdata [2] = '{32'd0, 32'd0};
   logic         hready [2];
   logic [31:0]  hrdata [2];
   logic         hresp  [2];
   logic [127:0] regq   [2];
   logic [3:0]   rwr    [2];

   int asserts = 0;
   int fails   = 0;

   op_t         ops[$];
   logic [31:0] mdl    [2][4];
   int          mdl_wr [2][4] = '{default: 0};
   int          obs_wr [2][4] = '{default: 0};

   logic [31:0] got_rdata [64];
   int          got_waits [64];
   bit          got_rw    [64];
   bit          got_rf    [64];
   logic [31:0] exp_rdata [64];
   int          exp_waits [64];
   bit          exp_rw    [64];
   bit          exp_rf    [64];

   always #5 clk = ~clk;

   ahb_regbank_fanin #(.DATA_WIDTH(32), .N_REGS(4), .ADDR_WIDTH(6), .READ_PIPE(0), .RESET_VAL(32'h0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .s_ahb_hsel(hsel[0]), .s_ahb_hwrite(hwrite[0]), .s_ahb_htrans(htrans[0]),
      .s_ahb_hsize(hsize[0]), .s_ahb_haddr(haddr[0]), .s_ahb_hwdata(hwdata[0]), .s_ahb_hready(hready[0]),
      .s_ahb_hrdata(hrdata[0]), .s_ahb_hresp(hresp[0]), .reg_q(regq[0]), .reg_wr(rwr[0]));

   ahb_regbank_fanin #(.DATA_WIDTH(32), .N_REGS(4), .ADDR_WIDTH(6), .READ_PIPE(1), .RESET_VAL(32'h0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .s_ahb_hsel(hsel[1]), .s_ahb_hwrite(hwrite[1]), .s_ahb_htrans(htrans[1]),
      .s_ahb_hsize(hsize[1]), .s_ahb_haddr(haddr[1]), .s_ahb_hwdata(hwdata[1]), .s_ahb_hready(hready[1]),
      .s_ahb_hrdata(hrdata[1]), .s_ahb_hresp(hresp[1]), .reg_q(regq[1]), .reg_wr(rwr[1]));

   always @(negedge clk) begin
      for (int mm = 0; mm < 2; mm++) begin
         for (int ii = 0; ii < 4; ii++) begin
            if (rwr[mm][ii]) obs_wr[mm][ii]++;
         end
      end
   end

   task automatic add_op(input bit sel, input logic [1:0] trans, input bit wr,
                         input logic [5:0] addr, input logic [2:0] size, input logic [31:0] wdata);
      op_t o;
      o.sel = sel; o.trans = trans; o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
      ops.push_back(o);
   endtask

   task automatic model_reset();
      for (int mm = 0; mm < 2; mm++)
         for (int i = 0; i < 4; i++) mdl[mm][i] = 32'h0;
   endtask

   // Register model: transfers take effect in bus order; illegal ones only raise an error.
   task automatic model_ops(input int m);
      for (int k = 0; k < ops.size(); k++) begin
         exp_rdata[k] = 32'h0; exp_waits[k] = 0; exp_rw[k] = 1'b0; exp_rf[k] = 1'b0;
         if (ops[k].sel && ops[k].trans >= 2'd2) begin
            int nbytes = 1 << ops[k].size;
            int idx    = int'(ops[k].addr) / 4;
            int off    = int'(ops[k].addr) % 4;
            if (ops[k].size > 3'd2 || (int'(ops[k].addr) % nbytes) != 0 || idx >= 4) begin
               exp_waits[k] = 1; exp_rw[k] = 1'b1; exp_rf[k] = 1'b1;
            end else if (ops[k].wr) begin
               for (int b = 0; b < nbytes; b++)
                  mdl[m][idx][(off+b)*8 +: 8] = ops[k].wdata[(off+b)*8 +: 8];
               mdl_wr[m][idx]++;
            end else begin
               exp_rdata[k] = mdl[m][idx];
               exp_waits[k] = m;
            end
         end
      end
   endtask

   // Pipelined AHB master: address of op n+1 overlaps the data phase of op n.
   task automatic run_ops(input int m);
      int  ptr = 0;
      int  dp = 0;
      int  cyc = 0;
      int  waits = 0;
      bit  dp_vld = 1'b0;
      bit  rwait = 1'b0;
      for (int k = 0; k < 64; k++) begin
         got_waits[k] = -1; got_rdata[k] = 'x; got_rw[k] = 1'b0; got_rf[k] = 1'b0;
      end
      while ((ptr < ops.size() || dp_vld) && cyc < 2000) begin
         @(posedge clk); #1;
         if (ptr < ops.size()) begin
            hsel[m] = ops[ptr].sel; htrans[m] = ops[ptr].trans; hwrite[m] = ops[ptr].wr;
            haddr[m] = ops[ptr].addr; hsize[m] = ops[ptr].size;
         end else begin
            hsel[m] = 1'b0; htrans[m] = 2'b00;
         end
         hwdata[m] = (dp_vld && ops[dp].wr) ? ops[dp].wdata : $urandom;
         @(negedge clk);
         if (dp_vld) begin
            if (hready[m]) begin
               got_rdata[dp] = hrdata[m]; got_rf[dp] = hresp[m];
               got_waits[dp] = waits; got_rw[dp] = rwait; dp_vld = 1'b0;
            end else begin
               waits++;
               rwait = rwait | hresp[m];
            end
         end
         if (ptr < ops.size() && hready[m]) begin
            if (ops[ptr].sel && ops[ptr].trans[1]) begin
               dp = ptr; dp_vld = 1'b1; waits = 0; rwait = 1'b0;
            end
            ptr++;
         end
         cyc++;
      end
      if (cyc >= 2000) begin
         asserts++; fails++;
         $display("FAIL run_ops_timeout m%0d: reached op %0d of %0d", m, ptr, ops.size());
      end
      @(posedge clk); #1;
      hsel[m] = 1'b0; htrans[m] = 2'b00;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         asserts++;
         if (hready[m] !== 1'b1 || hresp[m] !== 1'b0 || hrdata[m] !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus m%0d: hready %b hresp %b hrdata %h, expected 1 0 0", m, hready[m], hresp[m], hrdata[m]);
         end
         asserts++;
         if (regq[m] !== 128'h0 || rwr[m] !== 4'h0) begin
            fails++;
            $display("FAIL reset_regs m%0d: reg_q %h reg_wr %b, expected 0 0", m, regq[m], rwr[m]);
         end
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      for (int m = 0; m < 2; m++) begin
         ops.delete();
         add_op(1, 2'b10, 1, 6'h08, 3'd2, 32'hA5A5_1234);
         add_op(1, 2'b10, 0, 6'h08, 3'd2, 32'h0);
         model_ops(m);
         run_ops(m);
         asserts++;
         if (got_rdata[1] !== 32'hA5A5_1234 || got_waits[1] !== m) begin
            fails++;
            $display("FAIL wr_rd_literal m%0d: rdata %h waits %0d, expected a5a51234 %0d", m, got_rdata[1], got_waits[1], m);
         end
         for (int k = 0; k < ops.size(); k++) if (ops[k].sel && ops[k].trans[1]) begin
            asserts++;
            if (got_rdata[k] !== exp_rdata[k] || got_waits[k] !== exp_waits[k] || got_rw[k] !== exp_rw[k] || got_rf[k] !== exp_rf[k]) begin
               fails++;
               $display("FAIL wr_rd m%0d op%0d: rdata %h waits %0d resp %b%b, expected %h %0d %b%b", m, k,
                        got_rdata[k], got_waits[k], got_rw[k], got_rf[k], exp_rdata[k], exp_waits[k], exp_rw[k], exp_rf[k]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            asserts++;
            if (regq[m][i*32 +: 32] !== mdl[m][i] || obs_wr[m][i] !== mdl_wr[m][i]) begin
               fails++;
               $display("FAIL wr_rd_state m%0d reg%0d: value %h pulses %0d, expected %h %0d", m, i,
                        regq[m][i*32 +: 32], obs_wr[m][i], mdl[m][i], mdl_wr[m][i]);
            end
         end
      end
   endtask

   task automatic test_byte_write();
      for (int m = 0; m < 2; m++) begin
         ops.delete();
         add_op(1, 2'b10, 1, 6'h04, 3'd2, 32'hFFFF_FFFF);
         add_op(1, 2'b10, 1, 6'h06, 3'd0, 32'h0000_0000);
         add_op(1, 2'b10, 0, 6'h04, 3'd2, 32'h0);
         model_ops(m);
         run_ops(m);
         asserts++;
         if (got_rdata[2] !== 32'hFF00_FFFF) begin
            fails++;
            $display("FAIL byte_literal m%0d: rdata %h, expected ff00ffff", m, got_rdata[2]);
         end
         for (int k = 0; k < ops.size(); k++) if (ops[k].sel && ops[k].trans[1]) begin
            asserts++;
            if (got_rdata[k] !== exp_rdata[k] || got_waits[k] !== exp_waits[k] || got_rw[k] !== exp_rw[k] || got_rf[k] !== exp_rf[k]) begin
               fails++;
               $display("FAIL byte m%0d op%0d: rdata %h waits %0d resp %b%b, expected %h %0d %b%b", m, k,
                        got_rdata[k], got_waits[k], got_rw[k], got_rf[k], exp_rdata[k], exp_waits[k], exp_rw[k], exp_rf[k]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            asserts++;
            if (regq[m][i*32 +: 32] !== mdl[m][i] || obs_wr[m][i] !== mdl_wr[m][i]) begin
               fails++;
               $display("FAIL byte_state m%0d reg%0d: value %h pulses %0d, expected %h %0d", m, i,
                        regq[m][i*32 +: 32], obs_wr[m][i], mdl[m][i], mdl_wr[m][i]);
            end
         end
      end
   endtask

   task automatic test_errors();
      for (int m = 0; m < 2; m++) begin
         ops.delete();
         add_op(1, 2'b10, 1, 6'h10, 3'd2, 32'h1111_1111);
         add_op(1, 2'b10, 1, 6'h01, 3'd1, 32'h2222_2222);
         add_op(1, 2'b10, 1, 6'h00, 3'd3, 32'h3333_3333);
         add_op(1, 2'b10, 0, 6'h10, 3'd2, 32'h0);
         add_op(1, 2'b10, 0, 6'h04, 3'd2, 32'h0);
         model_ops(m);
         run_ops(m);
         for (int k = 0; k < ops.size(); k++) if (ops[k].sel && ops[k].trans[1]) begin
            asserts++;
            if (got_rdata[k] !== exp_rdata[k] || got_waits[k] !== exp_waits[k] || got_rw[k] !== exp_rw[k] || got_rf[k] !== exp_rf[k]) begin
               fails++;
               $display("FAIL error m%0d op%0d: rdata %h waits %0d resp %b%b, expected %h %0d %b%b", m, k,
                        got_rdata[k], got_waits[k], got_rw[k], got_rf[k], exp_rdata[k], exp_waits[k], exp_rw[k], exp_rf[k]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            asserts++;
            if (regq[m][i*32 +: 32] !== mdl[m][i] || obs_wr[m][i] !== mdl_wr[m][i]) begin
               fails++;
               $display("FAIL error_state m%0d reg%0d: value %h pulses %0d, expected %h %0d", m, i,
                        regq[m][i*32 +: 32], obs_wr[m][i], mdl[m][i], mdl_wr[m][i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int m = 0; m < 2; m++) begin
         ops.delete();
         for (int i = 0; i < 4; i++) add_op(1, (i == 0) ? 2'b10 : 2'b11, 1, 6'(i*4), 3'd2, 32'(i+1));
         for (int i = 0; i < 4; i++) add_op(1, (i == 0) ? 2'b10 : 2'b11, 0, 6'(i*4), 3'd2, 32'h0);
         model_ops(m);
         run_ops(m);
         for (int k = 0; k < ops.size(); k++) if (ops[k].sel && ops[k].trans[1]) begin
            asserts++;
            if (got_rdata[k] !== exp_rdata[k] || got_waits[k] !== exp_waits[k] || got_rw[k] !== exp_rw[k] || got_rf[k] !== exp_rf[k]) begin
               fails++;
               $display("FAIL burst m%0d op%0d: rdata %h waits %0d resp %b%b, expected %h %0d %b%b", m, k,
                        got_rdata[k], got_waits[k], got_rw[k], got_rf[k], exp_rdata[k], exp_waits[k], exp_rw[k], exp_rf[k]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            asserts++;
            if (regq[m][i*32 +: 32] !== mdl[m][i] || obs_wr[m][i] !== mdl_wr[m][i]) begin
               fails++;
               $display("FAIL burst_state m%0d reg%0d: value %h pulses %0d, expected %h %0d", m, i,
                        regq[m][i*32 +: 32], obs_wr[m][i], mdl[m][i], mdl_wr[m][i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int m = 0; m < 2; m++) begin
         ops.delete();
         for (int n = 0; n < 40; n++) begin
            bit         sel   = ($urandom_range(0, 9) != 0);
            logic [1:0] trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            logic [5:0] addr  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 31)) : 6'($urandom_range(0, 15));
            logic [2:0] size  = 3'($urandom_range(0, 3));
            add_op(sel, trans, bit'($urandom_range(0, 1)), addr, size, $urandom);
         end
         model_ops(m);
         run_ops(m);
         for (int k = 0; k < ops.size(); k++) if (ops[k].sel && ops[k].trans[1]) begin
            asserts++;
            if (got_rdata[k] !== exp_rdata[k] || got_waits[k] !== exp_waits[k] || got_rw[k] !== exp_rw[k] || got_rf[k] !== exp_rf[k]) begin
               fails++;
               $display("FAIL random m%0d op%0d a=%h s=%0d w=%0d: rdata %h waits %0d resp %b%b, expected %h %0d %b%b", m, k,
                        ops[k].addr, ops[k].size, ops[k].wr, got_rdata[k], got_waits[k], got_rw[k], got_rf[k],
                        exp_rdata[k], exp_waits[k], exp_rw[k], exp_rf[k]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            asserts++;
            if (regq[m][i*32 +: 32] !== mdl[m][i] || obs_wr[m][i] !== mdl_wr[m][i]) begin
               fails++;
               $display("FAIL random_state m%0d reg%0d: value %h pulses %0d, expected %h %0d", m, i,
                        regq[m][i*32 +: 32], obs_wr[m][i], mdl[m][i], mdl_wr[m][i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int m = 0; m < 2; m++) begin
         @(posedge clk); #1;
         hsel[m] = 1'b1; htrans[m] = 2'b10; hwrite[m] = 1'b1; haddr[m] = 6'h00; hsize[m] = 3'd2;
         @(posedge clk); #1;
         hsel[m] = 1'b0; htrans[m] = 2'b00; hwdata[m] = 32'hDEAD_BEEF; rst_n = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         model_reset();
         @(negedge clk);
         asserts++;
         if (regq[m][31:0] !== 32'h0 || hready[m] !== 1'b1 || hresp[m] !== 1'b0 || hrdata[m] !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid m%0d: reg0 %h hready %b hresp %b hrdata %h, expected 0 1 0 0", m,
                     regq[m][31:0], hready[m], hresp[m], hrdata[m]);
         end
         repeat (2) @(negedge clk);
         ops.delete();
         add_op(1, 2'b10, 0, 6'h00, 3'd2, 32'h0);
         model_ops(m);
         run_ops(m);
         asserts++;
         if (got_rdata[0] !== exp_rdata[0] || got_waits[0] !== exp_waits[0] || got_rf[0] !== exp_rf[0]) begin
            fails++;
            $display("FAIL reset_mid_read m%0d: rdata %h waits %0d resp %b, expected %h %0d %b", m,
                     got_rdata[0], got_waits[0], got_rf[0], exp_rdata[0], exp_waits[0], exp_rf[0]);
         end
         for (int i = 0; i < 4; i++) begin
            asserts++;
            if (regq[m][i*32 +: 32] !== mdl[m][i] || obs_wr[m][i] !== mdl_wr[m][i]) begin
               fails++;
               $display("FAIL reset_mid_state m%0d reg%0d: value %h pulses %0d, expected %h %0d", m, i,
                        regq[m][i*32 +: 32], obs_wr[m][i], mdl[m][i], mdl_wr[m][i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_write();
      test_errors();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/ahb_regbank_fanin.md
# ahb_regbank_fanin

Parametrised AHB-Lite slave with an integrated register bank of N_REGS words and a multiplexed read path, with byte-lane write strobes. Optional registered read fan-in and a two-cycle ERROR response on illegal accesses. Sits directly behind the AHB interconnect as a self-contained control/status block. Exposes every register to fabric logic, plus per-register write pulses.

## Interface
- DATA_WIDTH, 32: bus and register width; 32 or 64.
- N_REGS, 4: number of registers, ≥1.
- ADDR_WIDTH, $clog2(N_REGS)+$clog2(DATA_WIDTH/8): byte address width.
- READ_PIPE, 0: 0 = combinational read fan-in, zero wait states; 1 = registered fan-in, one wait state per read.
- RESET_VAL, 0: reset value loaded into every register.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_ahb_hsel  in  1  slave select.
- s_ahb_hwrite  in  1  1 = write.
- s_ahb_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- s_ahb_hsize  in  3  transfer size, log2 bytes.
- s_ahb_haddr  in  ADDR_WIDTH  byte address.
- s_ahb_hwdata  in  DATA_WIDTH  write data, valid in data phase.
- s_ahb_hready  out  1  transfer done / slave ready.
- s_ahb_hrdata  out  DATA_WIDTH  read data.
- s_ahb_hresp  out  1  0 = OKAY, 1 = ERROR.
- reg_q  out  N_REGS*DATA_WIDTH  flattened register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr  out  N_REGS  one-cycle pulse when register i is written.

## Operation
- Address phase is accepted when hsel & htrans[1] & hready. IDLE and BUSY transfers get a zero-wait OKAY and have no side effects.
- At acceptance, latch hwrite, register index = haddr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)], byte offset, and hsize.
- An access is illegal when any of these holds:
  - hsize > $clog2(DATA_WIDTH/8);
  - haddr is not aligned to 2^hsize;
  - the register index is ≥ N_REGS.
- Illegal accesses go to ERR1. No register changes and no reg_wr pulse.
- Write strobes: for lanes offset .. offset+2^hsize-1, the bytes are taken from the matching lanes of hwdata. All other lanes keep their value.
- Reads always return the full word. Lane selection is the master's job.
- FSM states: IDLE, WR_DATA, RD_DATA, RD_WAIT, ERR1, ERR2.
  - Legal write → WR_DATA.
  - Legal read → RD_DATA when READ_PIPE=0, RD_WAIT when READ_PIPE=1.
  - RD_WAIT → RD_DATA.
  - ERR1 → ERR2.
  - WR_DATA, RD_DATA and ERR2 go to the state implied by the next accepted address phase (pipelined), otherwise to IDLE.

## Timing
- Reset (rst_n=0 at a clock edge):
  - hready=1, hresp=0, hrdata=0, reg_wr=0;
  - all registers = RESET_VAL;
  - FSM = IDLE.
- Reset asserted mid-transfer abandons the transfer: no write, outputs take their reset values on the next edge.
- WR_DATA: hready=1, hresp=0. The register updates at the end of this cycle. reg_wr[i] is high during the cycle after the write.
- RD_DATA: hready=1, hresp=0, hrdata = selected register.
  - READ_PIPE=0: data phase completes in the cycle after the address phase.
  - READ_PIPE=1: RD_WAIT drives hready=0 first, then hrdata comes from a register.
- hrdata = 0 in every state other than RD_DATA.
- A write followed immediately by a read of the same address must return the new data. This holds in both READ_PIPE modes.
- ERR1: hready=0, hresp=1. ERR2: hready=1, hresp=1.
- An address phase is not accepted during ERR1 or RD_WAIT, because hready=0. During ERR2 it is accepted normally.
- Back-to-back legal accesses with READ_PIPE=0 complete at one transfer per cycle.

## Structure
- Package ahb_regbank_pkg holds:
  - htrans encodings;
  - FSM state enum;
  - HRESP_OKAY / HRESP_ERROR constants.
- Sub-module ahb_strb_gen: (offset, hsize) → DATA_WIDTH/8 lane strobe, purely combinational.
- Top level contains the FSM, the legality check, the register array and the read fan-in mux, with an optional pipeline register.

## Test plan
All scenarios use DATA_WIDTH=32, N_REGS=4 unless stated.
- Reset: after rst_n low for 2 cycles, every register reads 0, hready=1, hresp=0.
- Word write then read: write 0xA5A5_1234 to 0x8, read 0x8 in the next address phase.
  - Required: hrdata=0xA5A5_1234 with no wait state when READ_PIPE=0.
  - Required: exactly one hready=0 cycle when READ_PIPE=1.
  - Required: reg_wr=4'b0100 for one cycle.
- Byte write: after word write 0xFFFF_FFFF to 0x4, write byte 0x00 (hsize=0) to 0x6. Read 0x4 → 0xFF00_FFFF.
- Error cases, each giving hready 0→1 with hresp=1 on both cycles, no reg_wr and no register change:
  - out-of-range address 0x10;
  - misaligned halfword at 0x1;
  - hsize=3 on a 32-bit bus.
- Pipelined burst: NONSEQ+SEQ writes to 0x0, 0x4, 0x8, 0xC with data 1..4, followed by four reads. Required: reads return 1..4 with hready never low when READ_PIPE=0.
- Reset mid-transfer: rst_n=0 during WR_DATA of a write of 0xDEAD_BEEF to 0x0. Required: register 0 = 0 afterwards, FSM back in IDLE.
